// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU among NUM_REQ requesters
// Ports: clk/rst (sync, active-high); req_*_i packed per-requester request fields (lane i at [(i+1)*W-1:i*W]);
//        req_ready_o one-hot accept; alu_*_o registered ALU controls/operands; alu_*_i ALU results;
//        resp_valid_o/resp_id_o/resp_data_o/resp_carry_o/resp_overflow_o tagged response, resp_ready_i accept.
// Optional macro ALU_ARB_LOCK_EN adds req_lock_i for locked multi-precision chains with carry forwarding.
module alu_arbiter #(
    parameter int NUM_REQ            = 4,
    parameter int DATA_WIDTH         = 64,
    parameter int SHIFT_AMT          = $clog2(DATA_WIDTH),
    parameter int ID_WIDTH           = $clog2(NUM_REQ),
    parameter int SHIFT_OPCODE_WIDTH = 2,
    parameter int LOGIC_OPCODE_WIDTH = 3
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_REQ-1:0]                       req_valid_i,
    output logic [NUM_REQ-1:0]                       req_ready_o,
    input  logic [NUM_REQ-1:0]                       req_add_sub_mode_i,
    input  logic [NUM_REQ*SHIFT_OPCODE_WIDTH-1:0]    req_shift_mode_i,
    input  logic [NUM_REQ*LOGIC_OPCODE_WIDTH-1:0]    req_logic_opcode_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]            req_data_a_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]            req_data_b_i,
    input  logic [NUM_REQ-1:0]                       req_carry_in_i,
    input  logic [NUM_REQ*SHIFT_AMT-1:0]             req_shift_amt_i,
`ifdef ALU_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]                       req_lock_i,
`endif
    output logic                                     alu_add_sub_mode_o,
    output logic [SHIFT_OPCODE_WIDTH-1:0]            alu_shift_mode_o,
    output logic [LOGIC_OPCODE_WIDTH-1:0]            alu_logic_opcode_o,
    output logic [DATA_WIDTH-1:0]                    alu_data_a_o,
    output logic [DATA_WIDTH-1:0]                    alu_data_b_o,
    output logic                                     alu_carry_in_o,
    output logic [SHIFT_AMT-1:0]                     alu_shift_amt_o,
    input  logic [DATA_WIDTH-1:0]                    alu_data_out_i,
    input  logic                                     alu_carry_out_i,
    input  logic                                     alu_overflow_i,
    output logic                                     resp_valid_o,
    output logic [ID_WIDTH-1:0]                      resp_id_o,
    output logic [DATA_WIDTH-1:0]                    resp_data_o,
    output logic                                     resp_carry_o,
    output logic                                     resp_overflow_o,
    input  logic                                     resp_ready_i
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t              state_q;
    logic [ID_WIDTH-1:0] rr_q;
    logic [ID_WIDTH-1:0] gnt_id;
    logic [ID_WIDTH-1:0] idx;
    logic                gnt_any;
    logic                slot_free;
    logic [NUM_REQ-1:0]  cand;
    logic                cin_d;
    assign slot_free       = state_q == IDLE || resp_ready_i;
    assign resp_valid_o    = state_q == BUSY;
    assign resp_data_o     = alu_data_out_i;
    assign resp_carry_o    = alu_carry_out_i;
    assign resp_overflow_o = alu_overflow_i;
`ifdef ALU_ARB_LOCK_EN
    logic                lock_q;
    logic [ID_WIDTH-1:0] lock_id_q;
    logic                carry_q;
    assign cand = lock_q ? req_valid_i & (NUM_REQ'(1) << lock_id_q) : req_valid_i;
    // A grant while BUSY implies the previous response is handshaking now, so its carry is live on the ALU.
    assign cin_d = lock_q ? (state_q == BUSY ? alu_carry_out_i : carry_q) : req_carry_in_i[gnt_id];
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            carry_q   <= 1'b0;
        end else begin
            if (gnt_any) begin
                lock_q    <= req_lock_i[gnt_id];
                lock_id_q <= gnt_id;
            end
            if (state_q == BUSY && resp_ready_i) carry_q <= alu_carry_out_i;
        end
    end
`else
    assign cand  = req_valid_i;
    assign cin_d = req_carry_in_i[gnt_id];
`endif
    // Scan downward so the nearest requester after rr_q is the last (winning) assignment.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_WIDTH'((int'(rr_q) + k) % NUM_REQ);
            if (slot_free && cand[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
    end
    assign req_ready_o = gnt_any ? NUM_REQ'(1) << gnt_id : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= IDLE;
            rr_q               <= ID_WIDTH'(NUM_REQ - 1);
            resp_id_o          <= '0;
            alu_add_sub_mode_o <= 1'b0;
            alu_shift_mode_o   <= '0;
            alu_logic_opcode_o <= '0;
            alu_data_a_o       <= '0;
            alu_data_b_o       <= '0;
            alu_carry_in_o     <= 1'b0;
            alu_shift_amt_o    <= '0;
        end else if (gnt_any) begin
            state_q            <= BUSY;
            rr_q               <= gnt_id;
            resp_id_o          <= gnt_id;
            alu_add_sub_mode_o <= req_add_sub_mode_i[gnt_id];
            alu_shift_mode_o   <= req_shift_mode_i[gnt_id*SHIFT_OPCODE_WIDTH +: SHIFT_OPCODE_WIDTH];
            alu_logic_opcode_o <= req_logic_opcode_i[gnt_id*LOGIC_OPCODE_WIDTH +: LOGIC_OPCODE_WIDTH];
            alu_data_a_o       <= req_data_a_i[gnt_id*DATA_WIDTH +: DATA_WIDTH];
            alu_data_b_o       <= req_data_b_i[gnt_id*DATA_WIDTH +: DATA_WIDTH];
            alu_carry_in_o     <= cin_d;
            alu_shift_amt_o    <= req_shift_amt_i[gnt_id*SHIFT_AMT +: SHIFT_AMT];
        end else if (resp_ready_i) begin
            state_q <= IDLE;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural ALU model
module tb_alu_arbiter;
    localparam int N = 4;
    localparam int W = 64;
    localparam int SA = 6;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [N-1:0] req_add_sub_mode = '0;
    logic [N*2-1:0] req_shift_mode = '0;
    logic [N*3-1:0] req_logic_opcode = '0;
    logic [N*W-1:0] req_data_a = '0;
    logic [N*W-1:0] req_data_b = '0;
    logic [N-1:0] req_carry_in = '0;
    logic [N*SA-1:0] req_shift_amt = '0;
    logic [N-1:0] req_lock = '0;
    logic alu_add_sub_mode;
    logic [1:0] alu_shift_mode;
    logic [2:0] alu_logic_opcode;
    logic [W-1:0] alu_data_a, alu_data_b, alu_data_out;
    logic alu_carry_in, alu_carry_out, alu_overflow;
    logic [SA-1:0] alu_shift_amt;
    logic resp_valid, resp_carry, resp_overflow;
    logic resp_ready = 1'b0;
    logic [1:0] resp_id;
    logic [W-1:0] resp_data;
    logic [W:0] sum;
    logic [W-1:0] b_eff;
    int checks = 0;
    int errs = 0;
    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] data;
        logic         c;
        logic         v;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_add_sub_mode_i(req_add_sub_mode), .req_shift_mode_i(req_shift_mode),
        .req_logic_opcode_i(req_logic_opcode), .req_data_a_i(req_data_a),
        .req_data_b_i(req_data_b), .req_carry_in_i(req_carry_in),
        .req_shift_amt_i(req_shift_amt),
`ifdef ALU_ARB_LOCK_EN
        .req_lock_i(req_lock),
`endif
        .alu_add_sub_mode_o(alu_add_sub_mode), .alu_shift_mode_o(alu_shift_mode),
        .alu_logic_opcode_o(alu_logic_opcode), .alu_data_a_o(alu_data_a),
        .alu_data_b_o(alu_data_b), .alu_carry_in_o(alu_carry_in),
        .alu_shift_amt_o(alu_shift_amt), .alu_data_out_i(alu_data_out),
        .alu_carry_out_i(alu_carry_out), .alu_overflow_i(alu_overflow),
        .resp_valid_o(resp_valid), .resp_id_o(resp_id), .resp_data_o(resp_data),
        .resp_carry_o(resp_carry), .resp_overflow_o(resp_overflow),
        .resp_ready_i(resp_ready)
    );

    // Behavioural ALU: flags always from the adder; shift_mode 1/2 = shl/shr, logic 1 = xor.
    always_comb begin
        b_eff = alu_add_sub_mode ? ~alu_data_b : alu_data_b;
        sum = {1'b0, alu_data_a} + {1'b0, b_eff} + (W+1)'(alu_carry_in);
        alu_carry_out = sum[W];
        alu_overflow = (alu_data_a[W-1] == b_eff[W-1]) && (sum[W-1] != alu_data_a[W-1]);
        alu_data_out = alu_shift_mode == 2'd1 ? alu_data_a << alu_shift_amt :
                       alu_shift_mode == 2'd2 ? alu_data_a >> alu_shift_amt :
                       alu_logic_opcode == 3'd1 ? alu_data_a ^ alu_data_b : sum[W-1:0];
    end

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic sub, input logic [1:0] sh, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic cin, input logic [SA-1:0] amt);
        req_add_sub_mode[i] = sub;
        req_shift_mode[i*2 +: 2] = sh;
        req_logic_opcode[i*3 +: 3] = 3'd0;
        req_data_a[i*W +: W] = a;
        req_data_b[i*W +: W] = b;
        req_carry_in[i] = cin;
        req_shift_amt[i*SA +: SA] = amt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ck_ready(input string nm, input logic [N-1:0] exp);
        #1;
        chk(nm, W'(req_ready), W'(exp));
    endtask

    task automatic push(input logic [1:0] id, input logic [W-1:0] d, input logic c, input logic v);
        exp_q.push_back('{id: id, data: d, c: c, v: v});
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL unexpected_resp: got id=%0d data=%h expected none", resp_id, resp_data);
            end else begin
                e = exp_q.pop_front();
                chk("resp_id", W'(resp_id), W'(e.id));
                chk("resp_data", resp_data, e.data);
                chk("resp_carry", W'(resp_carry), W'(e.c));
                chk("resp_ovf", W'(resp_overflow), W'(e.v));
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_valid", W'(resp_valid), '0);
        chk("rst_id", W'(resp_id), '0);
        chk("rst_alu_a", alu_data_a, '0);
        chk("rst_alu_cin", W'(alu_carry_in), '0);
        chk("rst_ready", W'(req_ready), '0);
        // Round robin 0,1,2,3,0 at full throughput
        set_lane(0, 1'b0, 2'd0, 64'd5, 64'd7, 1'b0, 6'd0);
        set_lane(1, 1'b1, 2'd0, 64'd10, 64'd3, 1'b1, 6'd0);
        set_lane(2, 1'b0, 2'd1, 64'd3, 64'd0, 1'b0, 6'd4);
        set_lane(3, 1'b0, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 6'd0);
        push(2'd0, 64'd12, 1'b0, 1'b0);
        push(2'd1, 64'd7, 1'b1, 1'b0);
        push(2'd2, 64'h30, 1'b0, 1'b0);
        push(2'd3, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        push(2'd0, 64'd12, 1'b0, 1'b0);
        req_valid = 4'b1111;
        resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            ck_ready("rr_grant", 4'b0001 << (k % 4));
            step();
        end
        req_valid = '0;
        step();
        #1;
        chk("idle_valid", W'(resp_valid), '0);
        chk("idle_hold_a", alu_data_a, 64'd5);
        // Add with carry out from requester 2
        set_lane(2, 1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 6'd0);
        req_valid = 4'b0100;
        ck_ready("gnt2", 4'b0100);
        push(2'd2, 64'd0, 1'b1, 1'b0);
        step();
        req_valid = '0;
        step();
        // Backpressure then back-to-back grant to requester 0
        set_lane(3, 1'b0, 2'd0, 64'd100, 64'd23, 1'b0, 6'd0);
        set_lane(0, 1'b0, 2'd0, 64'd1, 64'd1, 1'b0, 6'd0);
        req_valid = 4'b1000;
        ck_ready("gnt3", 4'b1000);
        push(2'd3, 64'd123, 1'b0, 1'b0);
        step();
        resp_ready = 1'b0;
        req_valid = 4'b0011;
        for (int k = 0; k < 3; k++) begin
            ck_ready("stall_ready", 4'b0000);
            chk("stall_valid", W'(resp_valid), W'(1));
            chk("stall_data", resp_data, 64'd123);
            step();
        end
        resp_ready = 1'b1;
        ck_ready("b2b_gnt0", 4'b0001);
        push(2'd0, 64'd2, 1'b0, 1'b0);
        step();
        req_valid = '0;
        step();
        // Reset mid-operation discards the op and restores priority to requester 0
        req_valid = 4'b0010;
        ck_ready("gnt1", 4'b0010);
        step();
        req_valid = '0;
        resp_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("midrst_valid", W'(resp_valid), '0);
        chk("midrst_ready", W'(req_ready), '0);
        resp_ready = 1'b1;
        req_valid = 4'b1111;
        ck_ready("post_rst_gnt0", 4'b0001);
        push(2'd0, 64'd2, 1'b0, 1'b0);
        step();
        req_valid = '0;
        step();
        // Requester 3 alone is re-granted across the wrap
        req_valid = 4'b1000;
        ck_ready("wrap_gnt3a", 4'b1000);
        push(2'd3, 64'd123, 1'b0, 1'b0);
        step();
        ck_ready("wrap_gnt3b", 4'b1000);
        push(2'd3, 64'd123, 1'b0, 1'b0);
        step();
        req_valid = '0;
        step();
`ifdef ALU_ARB_LOCK_EN
        // 128-bit add in two locked ops; requester 0 held off until unlock
        set_lane(1, 1'b0, 2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 6'd0);
        req_lock = 4'b0010;
        req_valid = 4'b0010;
        ck_ready("lock_lo", 4'b0010);
        push(2'd1, 64'd0, 1'b1, 1'b0);
        step();
        set_lane(1, 1'b0, 2'd0, 64'd0, 64'd0, 1'b0, 6'd0);
        set_lane(0, 1'b0, 2'd0, 64'd5, 64'd7, 1'b0, 6'd0);
        req_lock = 4'b0000;
        req_valid = 4'b0011;
        ck_ready("lock_hi", 4'b0010);
        push(2'd1, 64'd1, 1'b0, 1'b0);
        step();
        ck_ready("unlock_gnt0", 4'b0001);
        push(2'd0, 64'd12, 1'b0, 1'b0);
        step();
        req_valid = '0;
        step();
`endif
        repeat (2) step();
        chk("drain", W'(exp_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
